// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a shared serial multiply-accumulate FIR datapath:
// sample handshake, tap walk, pipeline-aligned accumulate and result handoff.
module fir_mac_sequencer #(
   parameter  int NTAPS    = 21,
   parameter  int PIPE_LAT = 2,
   localparam int SEL_W    = $clog2(NTAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             shift_en,
   output logic             acc_clr,
   output logic [SEL_W-1:0] tap_sel,
   output logic             tap_vld,
   output logic             acc_en,
   output logic             out_load,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      DRAIN = 2'd2,
      LOAD  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [SEL_W-1:0] tap_sel_r;
   logic [DRN_W-1:0] drn_cnt_r;
   logic             out_valid_r;
   logic             accept_s;
   logic             tap_last_s;
   logic             drn_last_s;

   // Handshake decode and next-state selection
   always_comb begin
      state_nxt_s = state_r;
      tap_last_s  = (tap_sel_r == SEL_W'(NTAPS - 1));
      drn_last_s  = (drn_cnt_r == DRN_W'(PIPE_LAT - 1));
      accept_s    = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s = in_valid & (~out_valid_r | out_ready);
            if (accept_s) begin
               state_nxt_s = MAC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MAC: begin
            if (tap_last_s) begin
               state_nxt_s = (PIPE_LAT > 0) ? DRAIN : LOAD;
            end else begin
               state_nxt_s = MAC;
            end
         end
         DRAIN: begin
            if (drn_last_s) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = DRAIN;
            end
         end
         LOAD:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Tap and drain counters; both rest at zero outside their own state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tap_sel_r <= {SEL_W{1'b0}};
         drn_cnt_r <= {DRN_W{1'b0}};
      end else begin
         if (state_r == MAC && !tap_last_s) begin
            tap_sel_r <= tap_sel_r + SEL_W'(1);
         end else begin
            tap_sel_r <= {SEL_W{1'b0}};
         end
         if (state_r == DRAIN && !drn_last_s) begin
            drn_cnt_r <= drn_cnt_r + DRN_W'(1);
         end else begin
            drn_cnt_r <= {DRN_W{1'b0}};
         end
      end
   end

   // Result flag: set by LOAD, cleared when downstream takes it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_r <= 1'b0;
      end else if (state_r == LOAD) begin
         out_valid_r <= 1'b1;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // acc_en follows tap_vld through the mux/multiplier pipeline depth
   generate
      if (PIPE_LAT == 0) begin : g_no_pipe
         assign acc_en = tap_vld;
      end else begin : g_pipe
         logic [PIPE_LAT-1:0] acc_pipe_r;
         // Delay line for the accumulate enable
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               acc_pipe_r <= {PIPE_LAT{1'b0}};
            end else begin
               acc_pipe_r[0] <= tap_vld;
               for (int i = 1; i < PIPE_LAT; i++) begin
                  acc_pipe_r[i] <= acc_pipe_r[i-1];
               end
            end
         end
         assign acc_en = acc_pipe_r[PIPE_LAT-1];
      end
   endgenerate

   assign in_ready  = (state_r == IDLE) & (~out_valid_r | out_ready);
   assign shift_en  = accept_s;
   assign acc_clr   = accept_s;
   assign tap_sel   = tap_sel_r;
   assign tap_vld   = (state_r == MAC);
   assign out_load  = (state_r == LOAD);
   assign out_valid = out_valid_r;
   assign busy      = (state_r != IDLE);

endmodule
